// File: rtl/cdc_handshake_tx.sv
// Transmit end of a 4-phase req/ack clock-domain crossing; ack_i is synchronised into clock_i.
// Optional per-phase ack timeout and timeout_o port: define CDC_TX_TIMEOUT_EN.
module cdc_handshake_tx #(
   parameter int WIDTH          = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic [WIDTH-1:0] data_o,
   output logic             req_o,
   input  logic             ack_i,
   output logic             busy_o,
   output logic             done_o
`ifdef CDC_TX_TIMEOUT_EN
   ,
   output logic             timeout_o
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

   state_t                 r_state, w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_ack_s;
   logic [WIDTH-1:0]       w_data_nxt;
   logic                   w_req_nxt;
   logic                   w_done_nxt;
   logic                   w_abandoned;

   if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("cdc_handshake_tx: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
   end

   // NOTE: ack_i is asynchronous; only the last flop of the chain may feed any logic.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) r_sync <= '0;
      else          r_sync <= {r_sync[SYNC_STAGES-2:0], ack_i};
   end

   assign w_ack_s = r_sync[SYNC_STAGES-1];
   assign ready_o = (r_state == IDLE) && !w_ack_s;
   assign busy_o  = (r_state != IDLE);

`ifdef CDC_TX_TIMEOUT_EN
   localparam int              CW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_abandon, w_abandon_nxt;
   logic          w_timeout_nxt;
   logic          w_tmo_hit;

   assign w_tmo_hit   = (r_cnt == LAST);
   assign w_abandoned = r_abandon;
`else
   assign w_abandoned = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = data_o;
      w_req_nxt   = req_o;
      w_done_nxt  = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
      w_timeout_nxt = 1'b0;
      w_abandon_nxt = r_abandon;
`endif
      case (r_state)
         IDLE: begin
            if (valid_i && ready_o) begin
               w_data_nxt  = data_i;
               w_req_nxt   = 1'b1;
               w_state_nxt = REQ;
            end
         end
         REQ: begin
            if (w_ack_s) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = RELEASE;
            end
`ifdef CDC_TX_TIMEOUT_EN
            else if (w_tmo_hit) begin
               // Abandoned transfer still waits for ack low, but never reports done.
               w_req_nxt     = 1'b0;
               w_timeout_nxt = 1'b1;
               w_abandon_nxt = 1'b1;
               w_state_nxt   = RELEASE;
            end
`endif
         end
         RELEASE: begin
            if (!w_ack_s) begin
               w_done_nxt  = !w_abandoned;
               w_state_nxt = IDLE;
            end
`ifdef CDC_TX_TIMEOUT_EN
            else if (w_tmo_hit) begin
               w_timeout_nxt = 1'b1;
               w_state_nxt   = IDLE;
            end
`endif
         end
         default: w_state_nxt = IDLE;
      endcase
`ifdef CDC_TX_TIMEOUT_EN
      if (w_state_nxt == IDLE)       w_abandon_nxt = 1'b0;
      if (w_state_nxt != r_state)    w_cnt_nxt = '0;
      else if (r_state != IDLE)      w_cnt_nxt = r_cnt + 1'b1;
      else                           w_cnt_nxt = '0;
`endif
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state <= IDLE;
         data_o  <= '0;
         req_o   <= 1'b0;
         done_o  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         data_o  <= w_data_nxt;
         req_o   <= w_req_nxt;
         done_o  <= w_done_nxt;
      end
   end

`ifdef CDC_TX_TIMEOUT_EN
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_cnt     <= '0;
         r_abandon <= 1'b0;
         timeout_o <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_abandon <= w_abandon_nxt;
         timeout_o <= w_timeout_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: cycle vector table, corner sequences, and a
// randomised responder checked against a transfer-level reference model.
module tb_cdc_handshake_tx;

   localparam int WIDTH          = 8;
   localparam int SYNC_STAGES    = 2;
   localparam int TIMEOUT_CYCLES = 16;

   logic             clock_i = 1'b0;
   logic             reset_i = 1'b0;
   logic [WIDTH-1:0] data_i  = '0;
   logic             valid_i = 1'b0;
   logic             ack_i   = 1'b0;
   logic             ready_o, req_o, busy_o, done_o;
   logic [WIDTH-1:0] data_o;
`ifdef CDC_TX_TIMEOUT_EN
   logic             timeout_o;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock_i = ~clock_i;

   cdc_handshake_tx #(
      .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clock_i(clock_i), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
      .ready_o(ready_o), .data_o(data_o), .req_o(req_o), .ack_i(ack_i),
      .busy_o(busy_o), .done_o(done_o)
`ifdef CDC_TX_TIMEOUT_EN
      , .timeout_o(timeout_o)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clock_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic a);
      valid_i = v;
      data_i  = d;
      ack_i   = a;
   endtask

   task automatic reset_pulse();
      @(negedge clock_i);
      reset_i = 1'b0;
      drive(1'b0, '0, 1'b0);
      step();
      @(negedge clock_i);
      reset_i = 1'b1;
      #1;
   endtask

   typedef struct {
      logic             v;
      logic [WIDTH-1:0] d;
      logic             a;
      logic             rdy;
      logic             bsy;
      logic             req;
      logic [WIDTH-1:0] dout;
      logic             done;
   } vec_t;

   vec_t tbl[23];

   // Reference model state: transfer in flight, request still raised, held word.
   logic             m_busy, m_req, m_done, m_ack_s, m_ready;
   logic [WIDTH-1:0] m_data;
   logic             ack_hist[$];
   int               m_accepts, m_dones, dut_dones, resp_cnt;

   initial begin
      // Basic transfer A5, held 3C accepted only after done, then a 5-cycle stray ack.
      tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
      tbl[1]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
      tbl[2]  = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
      tbl[3]  = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
      tbl[4]  = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
      tbl[5]  = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
      tbl[6]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
      tbl[7]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1};
      tbl[8]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0};
      tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0};
      tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0};
      tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0};
      tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0};
      tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0};
      tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1};
      tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0};
      tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0};
      tbl[17] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0};
      tbl[18] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0};
      tbl[19] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0};
      tbl[20] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0};
      tbl[21] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0};
      tbl[22] = '{1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0};

      // Reset held with valid_i high.
      drive(1'b1, 8'hFF, 1'b0);
      repeat (3) @(posedge clock_i);
      #1;
      check("rst req_o", req_o, 0);
      check("rst data_o", data_o, 0);
      check("rst done_o", done_o, 0);
      check("rst busy_o", busy_o, 0);
      @(negedge clock_i);
      valid_i = 1'b0;
      reset_i = 1'b1;
      #1;
      check("post-rst ready_o", ready_o, 1);

      for (int i = 0; i < 23; i++) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].a);
         step();
         check($sformatf("vec%0d ready_o", i), ready_o, tbl[i].rdy);
         check($sformatf("vec%0d busy_o", i), busy_o, tbl[i].bsy);
         check($sformatf("vec%0d req_o", i), req_o, tbl[i].req);
         check($sformatf("vec%0d data_o", i), data_o, tbl[i].dout);
         check($sformatf("vec%0d done_o", i), done_o, tbl[i].done);
      end

      // Reset while waiting for ack.
      drive(1'b1, 8'h11, 1'b0);
      step();
      check("mid accept req_o", req_o, 1);
      check("mid accept data_o", data_o, 8'h11);
      drive(1'b0, 8'h00, 1'b0);
      step();
      step();
      @(negedge clock_i);
      reset_i = 1'b0;
      #1;
      check("mid rst req_o", req_o, 0);
      check("mid rst busy_o", busy_o, 0);
      check("mid rst done_o", done_o, 0);
      check("mid rst data_o", data_o, 0);
      step();
      @(negedge clock_i);
      reset_i = 1'b1;
      #1;
      check("mid rst ready_o", ready_o, 1);
      begin
         int seen_done = 0;
         repeat (6) begin
            step();
            if (done_o || busy_o) seen_done++;
         end
         check("mid rst quiet after release", seen_done, 0);
      end

      // Ack never arrives.
      drive(1'b1, 8'h5A, 1'b0);
      step();
      drive(1'b0, 8'h00, 1'b0);
      check("stuck accept req_o", req_o, 1);
`ifdef CDC_TX_TIMEOUT_EN
      begin
         int early = 0;
         for (int k = 1; k < TIMEOUT_CYCLES; k++) begin
            step();
            if (timeout_o || !req_o || done_o) early++;
         end
         check("tmo no early pulse", early, 0);
      end
      step();
      check("tmo pulse", timeout_o, 1);
      check("tmo req_o low", req_o, 0);
      check("tmo no done_o", done_o, 0);
      step();
      check("tmo pulse ends", timeout_o, 0);
      check("tmo abandon no done_o", done_o, 0);
      check("tmo back idle", busy_o, 0);
`else
      begin
         int drops = 0;
         repeat (110) begin
            step();
            if (!req_o || done_o) drops++;
         end
         check("no-tmo req_o held", drops, 0);
      end
`endif
      reset_pulse();

      // Randomised traffic against the reference model.
      m_busy = 1'b0; m_req = 1'b0; m_data = '0;
      m_accepts = 0; m_dones = 0; dut_dones = 0; resp_cnt = 0;
      ack_hist = {};
      repeat (SYNC_STAGES) ack_hist.push_back(1'b0);
      for (int c = 0; c < 2000; c++) begin
         logic             v, a;
         logic [WIDTH-1:0] d;
         v = ($urandom_range(0, 2) != 0);
         d = WIDTH'($urandom);
         a = ack_i;
         if (req_o != ack_i) begin
            if (resp_cnt == 0) begin
               a = req_o;
               resp_cnt = $urandom_range(0, 5);
            end else resp_cnt--;
         end else if (!req_o && !ack_i && $urandom_range(0, 39) == 0) begin
            a = 1'b1;
            resp_cnt = $urandom_range(0, 3);
         end
         drive(v, d, a);

         m_ack_s = ack_hist[0];
         m_ready = !m_busy && !m_ack_s;
         m_done  = 1'b0;
         if (!m_busy) begin
            if (v && m_ready) begin
               m_data = d;
               m_req  = 1'b1;
               m_busy = 1'b1;
               m_accepts++;
            end
         end else if (m_req) begin
            if (m_ack_s) m_req = 1'b0;
         end else if (!m_ack_s) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_dones++;
         end
         void'(ack_hist.pop_front());
         ack_hist.push_back(a);

         step();
         if (done_o) dut_dones++;
         check($sformatf("rnd%0d ready_o", c), ready_o, !m_busy && !ack_hist[0]);
         check($sformatf("rnd%0d busy_o", c), busy_o, m_busy);
         check($sformatf("rnd%0d req_o", c), req_o, m_req);
         check($sformatf("rnd%0d data_o", c), data_o, m_data);
         check($sformatf("rnd%0d done_o", c), done_o, m_done);
`ifdef CDC_TX_TIMEOUT_EN
         check($sformatf("rnd%0d timeout_o", c), timeout_o, 0);
`endif
      end
      check("rnd done count", dut_dones, m_dones);
      check("rnd enough traffic", (m_accepts > 20), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
